// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: turns a valid/ready request/response handshake into
// APB4 SETUP/ACCESS transfers, one at a time, honouring PREADY wait states.
// Optional feature macro: APB4_MASTER_TIMEOUT_EN aborts an ACCESS phase that
// has waited TIMEOUT_CYCLES cycles with PREADY low (rsp_err = 1, rsp_rdata = 0).
module apb4_master_bridge #(
    parameter int PADDR_SIZE     = 32,
    parameter int PDATA_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [PADDR_SIZE-1:0]     req_addr,
    input  logic                      req_write,
    input  logic [PDATA_SIZE-1:0]     req_wdata,
    input  logic [PDATA_SIZE/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PDATA_SIZE-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [PADDR_SIZE-1:0]     PADDR,
    output logic [PDATA_SIZE-1:0]     PWDATA,
    output logic [PDATA_SIZE/8-1:0]   PSTRB,
    output logic [2:0]                PPROT,
    input  logic [PDATA_SIZE-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int STRB_W = PDATA_SIZE / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
    logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [PDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif

    // Next-state and registered-output logic; everything holds unless changed.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB4_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Reads must present zero strobes; zero write data keeps the bus quiet.
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : '0;
                    pstrb_d  = req_write ? req_strb  : '0;
                    pprot_d  = req_prot;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB4_MASTER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = RESP;
                end
`ifdef APB4_MASTER_TIMEOUT_EN
                // This is the TIMEOUT_CYCLES-th waited ACCESS cycle: give up.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB4_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB4_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: directed scenarios plus a
// randomized sweep checked against a transaction-level reference model.
module tb_apb4_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;

    apb4_master_bridge #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered by do_xfer for the scenario tasks to judge.
    logic [AW-1:0] o_paddr;
    logic          o_pwrite;
    logic [DW-1:0] o_pwdata;
    logic [SW-1:0] o_pstrb;
    logic [2:0]    o_pprot;
    logic [DW-1:0] o_rdata;
    logic          o_err, o_setup_ok, o_stable, o_got_rsp, o_hold_ok, o_done_ok;
    int            o_lat, o_psel_cyc;

    // Drives one request and plays the APB slave. 'waits' = ACCESS cycles with
    // PREADY low before PREADY goes high; 'hold' = cycles rsp_ready is held low.
    // Outside ACCESS the slave inputs carry junk that must be ignored.
    task automatic do_xfer(input logic [AW-1:0] addr, input logic wr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                           input logic [2:0] prot, input int waits,
                           input logic [DW-1:0] prdata, input logic slverr,
                           input int hold);
        int acc;
        acc = 0; o_lat = 0; o_psel_cyc = 0; o_stable = 1'b1; o_got_rsp = 1'b0;
        o_hold_ok = 1'b1; o_done_ok = 1'b0; o_setup_ok = 1'b0;
        o_rdata = '0; o_err = 1'b0;
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata;
        req_strb = strb; req_prot = prot;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = DW'($urandom);
        @(posedge PCLK); #1;
        req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = DW'($urandom);
        req_strb = SW'($urandom); req_prot = 3'($urandom); req_write = 1'($urandom);
        o_setup_ok = (PSEL === 1'b1) && (PENABLE === 1'b0) && (req_ready === 1'b0);
        o_paddr = PADDR; o_pwrite = PWRITE; o_pwdata = PWDATA; o_pstrb = PSTRB; o_pprot = PPROT;
        o_psel_cyc = (PSEL === 1'b1) ? 1 : 0;
        for (int e = 1; e <= 200 && !o_got_rsp; e++) begin
            if (PSEL === 1'b1 && PENABLE === 1'b1) begin
                PREADY  = (acc >= waits);
                PSLVERR = (acc >= waits) ? slverr : 1'($urandom);
                PRDATA  = (acc >= waits) ? prdata : DW'($urandom);
                acc++;
            end else begin
                PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = DW'($urandom);
            end
            @(posedge PCLK); #1;
            if (PSEL === 1'b1) begin
                o_psel_cyc++;
                if (PADDR !== o_paddr || PWRITE !== o_pwrite || PWDATA !== o_pwdata ||
                    PSTRB !== o_pstrb || PPROT !== o_pprot) o_stable = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                o_got_rsp = 1'b1; o_lat = e;
            end
        end
        if (!o_got_rsp) begin
            PRESETn = 1'b0; #2; PRESETn = 1'b1;
            return;
        end
        o_rdata = rsp_rdata; o_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = DW'($urandom);
            @(posedge PCLK); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== o_rdata || rsp_err !== o_err ||
                req_ready !== 1'b0 || PSEL !== 1'b0) o_hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        o_done_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (PSEL === 1'b0);
        rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT} !== '0) begin n_bad++; $display("FAIL reset_apb: got %h want 0", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT}); end
        n_cmp++; if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin n_bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_rdata, rsp_err}); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        @(posedge PCLK); #1; PRESETn = 1'b1;
        @(posedge PCLK); #1;
        n_cmp++; if (req_ready !== 1'b1 || PSEL !== 1'b0) begin n_bad++; $display("FAIL reset_release: got ready=%b psel=%b want 1 0", req_ready, PSEL); end
    endtask

    task automatic test_zero_wait_read();
        do_xfer(32'h1000_0004, 1'b0, 32'hCAFE_0001, 4'hF, 3'b010, 0, 32'hDEAD_BEEF, 1'b0, 0);
        n_cmp++; if (o_got_rsp !== 1'b1 || o_lat + 1 !== 3) begin n_bad++; $display("FAIL zr_latency: got %0d want 3 (rsp=%b)", o_lat + 1, o_got_rsp); end
        n_cmp++; if (o_psel_cyc !== 2) begin n_bad++; $display("FAIL zr_psel_cycles: got %0d want 2", o_psel_cyc); end
        n_cmp++; if (o_setup_ok !== 1'b1) begin n_bad++; $display("FAIL zr_setup_phase: got %b want 1", o_setup_ok); end
        n_cmp++; if ({o_paddr, o_pwrite, o_pstrb, o_pwdata, o_pprot} !== {32'h1000_0004, 1'b0, 4'h0, 32'h0, 3'b010}) begin n_bad++; $display("FAIL zr_apb_fields: got %h %b %h %h %b", o_paddr, o_pwrite, o_pstrb, o_pwdata, o_pprot); end
        n_cmp++; if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin n_bad++; $display("FAIL zr_rsp: got %h/%b want deadbeef/0", o_rdata, o_err); end
        n_cmp++; if (o_done_ok !== 1'b1) begin n_bad++; $display("FAIL zr_rsp_done: got %b want 1", o_done_ok); end
    endtask

    task automatic test_write_waits();
        do_xfer(32'h2000_0010, 1'b1, 32'h0000_0007, 4'hF, 3'b001, 3, 32'h5555_AAAA, 1'b0, 0);
        n_cmp++; if (o_got_rsp !== 1'b1 || o_lat + 1 !== 6) begin n_bad++; $display("FAIL ww_latency: got %0d want 6 (rsp=%b)", o_lat + 1, o_got_rsp); end
        n_cmp++; if (o_psel_cyc !== 5) begin n_bad++; $display("FAIL ww_psel_cycles: got %0d want 5", o_psel_cyc); end
        n_cmp++; if (o_stable !== 1'b1) begin n_bad++; $display("FAIL ww_stable: got %b want 1", o_stable); end
        n_cmp++; if ({o_paddr, o_pwrite, o_pstrb, o_pwdata} !== {32'h2000_0010, 1'b1, 4'hF, 32'h7}) begin n_bad++; $display("FAIL ww_apb_fields: got %h %b %h %h", o_paddr, o_pwrite, o_pstrb, o_pwdata); end
        n_cmp++; if (o_rdata !== 32'h0 || o_err !== 1'b0) begin n_bad++; $display("FAIL ww_rsp: got %h/%b want 0/0", o_rdata, o_err); end
    endtask

    task automatic test_slave_error();
        do_xfer(32'h3000_0000, 1'b0, 32'h0, 4'h3, 3'b000, 1, 32'h0000_1234, 1'b1, 0);
        n_cmp++; if (o_got_rsp !== 1'b1 || o_err !== 1'b1) begin n_bad++; $display("FAIL se_err: got %b want 1", o_err); end
        n_cmp++; if (o_rdata !== 32'h1234) begin n_bad++; $display("FAIL se_rdata: got %h want 1234", o_rdata); end
    endtask

    task automatic test_backpressure();
        do_xfer(32'h4000_0008, 1'b0, 32'h0, 4'h0, 3'b100, 0, 32'hA5A5_0F0F, 1'b0, 5);
        n_cmp++; if (o_hold_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %b want 1", o_hold_ok); end
        n_cmp++; if (o_rdata !== 32'hA5A5_0F0F) begin n_bad++; $display("FAIL bp_rdata: got %h want a5a50f0f", o_rdata); end
        n_cmp++; if (o_done_ok !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", o_done_ok); end
    endtask

    task automatic test_reset_mid_access();
        logic quiet;
        req_valid = 1'b1; req_addr = 32'h5000_0000; req_write = 1'b1;
        req_wdata = 32'h1111_2222; req_strb = 4'hF; req_prot = 3'b011; PREADY = 1'b0;
        @(posedge PCLK); #1; req_valid = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #2;
        n_cmp++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin n_bad++; $display("FAIL rm_in_access: got psel=%b pen=%b want 1 1", PSEL, PENABLE); end
        PRESETn = 1'b0; #1;
        n_cmp++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL rm_async_clear: got %b want 000", {PSEL, PENABLE, rsp_valid}); end
        n_cmp++; if ({PADDR, PWDATA, PSTRB, PWRITE} !== '0) begin n_bad++; $display("FAIL rm_regs_clear: got %h want 0", {PADDR, PWDATA, PSTRB, PWRITE}); end
        @(posedge PCLK); #1; PRESETn = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PREADY = 1'b1; PSLVERR = 1'($urandom);
            @(posedge PCLK); #1;
            if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
        end
        PREADY = 1'b0;
        n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL rm_no_response: got %b want 1", quiet); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a; logic w; logic [DW-1:0] wd, rd; logic [SW-1:0] s;
        logic [2:0] p; logic se; int wt, hd;
        for (int t = 0; t < 16; t++) begin
            a = AW'($urandom); w = 1'($urandom); wd = DW'($urandom); rd = DW'($urandom);
            s = SW'($urandom); p = 3'($urandom); se = 1'($urandom);
            wt = $urandom_range(0, 3); hd = $urandom_range(0, 2);
            do_xfer(a, w, wd, s, p, wt, rd, se, hd);
            // Reference: latency 2 + waits edges; reads present zero strobes/data
            // and return PRDATA; writes return zero.
            n_cmp++; if (o_got_rsp !== 1'b1 || o_lat !== 2 + wt) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, o_lat, 2 + wt); end
            n_cmp++; if ({o_paddr, o_pwrite, o_pprot} !== {a, w, p}) begin n_bad++; $display("FAIL rnd%0d_ctrl: got %h %b %b want %h %b %b", t, o_paddr, o_pwrite, o_pprot, a, w, p); end
            n_cmp++; if ({o_pwdata, o_pstrb} !== (w ? {wd, s} : '0)) begin n_bad++; $display("FAIL rnd%0d_wdata_strb: got %h %h", t, o_pwdata, o_pstrb); end
            n_cmp++; if ({o_rdata, o_err} !== {(w ? '0 : rd), se}) begin n_bad++; $display("FAIL rnd%0d_rsp: got %h/%b want %h/%b", t, o_rdata, o_err, (w ? 32'h0 : rd), se); end
            n_cmp++; if ({o_stable, o_hold_ok, o_done_ok} !== 3'b111) begin n_bad++; $display("FAIL rnd%0d_handshake: got %b want 111", t, {o_stable, o_hold_ok, o_done_ok}); end
        end
    endtask

`ifdef APB4_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        do_xfer(32'h6000_0000, 1'b0, 32'h0, 4'h0, 3'b000, 1000, 32'hFFFF_FFFF, 1'b0, 0);
        n_cmp++; if (o_got_rsp !== 1'b1 || o_psel_cyc !== 5 || o_lat !== 5) begin n_bad++; $display("FAIL to_abort_timing: got psel=%0d lat=%0d want 5 5", o_psel_cyc, o_lat); end
        n_cmp++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin n_bad++; $display("FAIL to_abort_rsp: got %h/%b want 0/1", o_rdata, o_err); end
        do_xfer(32'h6000_0004, 1'b0, 32'h0, 4'h0, 3'b000, 3, 32'h0BAD_F00D, 1'b0, 0);
        n_cmp++; if (o_lat !== 5 || o_err !== 1'b0 || o_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL to_limit_ready: got lat=%0d %h/%b want 5 0badf00d/0", o_lat, o_rdata, o_err); end
    endtask
`else
    task automatic test_long_wait();
        do_xfer(32'h7000_0000, 1'b0, 32'h0, 4'h0, 3'b000, 12, 32'h0000_C0DE, 1'b0, 0);
        n_cmp++; if (o_got_rsp !== 1'b1 || o_lat !== 14 || o_rdata !== 32'hC0DE || o_err !== 1'b0) begin n_bad++; $display("FAIL long_wait: got lat=%0d %h/%b want 14 c0de/0", o_lat, o_rdata, o_err); end
    endtask
`endif

    initial begin
        PRESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        test_reset();
        test_zero_wait_read();
        test_write_waits();
        test_slave_error();
        test_backpressure();
        test_reset_mid_access();
        test_random();
`ifdef APB4_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
